// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Shares sender_uart between two byte producers and paces bytes by slot timer.
// Option : UART_SCHED_RR_EN selects round-robin ties (default: requester 0 wins)
// Rev    : 1.0
// ============================================================================
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_CYCLES   = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0,
  input  logic [7:0]       data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [7:0]       data1,
  output logic             ack1,
  output logic [7:0]       tx_data,
  output logic             ready,
  output logic             busy,
  output logic             grant,
  output logic [CNT_W-1:0] byte_count
);

  localparam int c_SLOT_CYCLES = CLKS_PER_BIT * 10 + GAP_CYCLES;
  localparam int c_TMR_W       = $clog2(c_SLOT_CYCLES);
  // LAUNCH and the return through IDLE take two of the slot's clocks
  localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(c_SLOT_CYCLES - 3);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LAUNCH = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [c_TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               grant_q, grant_d;
  logic               ready_q, ready_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic w_start;
  logic w_win;

  assign w_start = (state_q == c_IDLE) & en & (req0 | req1);

`ifdef UART_SCHED_RR_EN
  logic ptr_q, ptr_d;

  assign w_win = req1 & (~req0 | ptr_q);
  assign ptr_d = w_start ? ~w_win : ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`else
  assign w_win = req1 & ~req0;
`endif

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    ready_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    case (state_q)
      c_IDLE: begin
        busy_d = 1'b0;
        if (w_start) begin
          state_d   = c_LAUNCH;
          tx_data_d = w_win ? data1 : data0;
          grant_d   = w_win;
          ready_d   = 1'b1;
          ack0_d    = ~w_win;
          ack1_d    = w_win;
          busy_d    = 1'b1;
        end
      end
      c_LAUNCH: begin
        state_d = c_WAIT;
        tmr_d   = c_TMR_LOAD;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      c_WAIT: begin
        if (tmr_q == '0) begin
          state_d = c_IDLE;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - c_TMR_ONE;
        end
      end
      default: begin
        state_d = c_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= c_IDLE;
      tmr_q     <= '0;
      tx_data_q <= 8'h00;
      grant_q   <= 1'b0;
      ready_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign ready      = ready_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign busy       = busy_q;
  assign byte_count = cnt_q;

endmodule
`default_nettype wire
